// File: rtl/csa_seq_multiplier.sv
// Sequential unsigned N x N multiplier: one 2N-bit carry-save adder folds in a
// partial product per cycle, then a single carry-propagate add resolves the result.

module carrysave_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

module csa_seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);
  localparam int W  = 2 * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    a_r, b_r;
  logic [W-1:0]    sum_r, carry_r;
  logic [W-1:0]    carry_sh, pp, csa_s, csa_c;
  logic [IW-1:0]   idx;
  logic            last_idx;

  // Carry from bit W-1 falls off the top; exact because a*b < 2^W.
  assign carry_sh = {carry_r[W-2:0], 1'b0};
  assign pp       = b_r[idx] ? ({{N{1'b0}}, a_r} << idx) : '0;
  assign last_idx = (idx == IW'(N - 1));

  carrysave_adder #(.W(W)) u_csa (
    .x (sum_r),
    .y (carry_sh),
    .z (pp),
    .s (csa_s),
    .c (csa_c)
  );

  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = ACCUM;
      ACCUM:   if (last_idx)  state_nxt = RESOLVE;
      RESOLVE:                state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because product must read zero
  // after reset and an aborted operation must leave no residue behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= '0;
      idx     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            sum_r   <= '0;
            carry_r <= '0;
            idx     <= '0;
          end
        end
        ACCUM: begin
          sum_r   <= csa_s;
          carry_r <= csa_c;
          idx     <= idx + IW'(1);
        end
        RESOLVE: product <= sum_r + carry_sh;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ACCUM) || (state == RESOLVE);

endmodule
